bruin_motion_ctrl: RTL and testbench

//  Game-level controller that sequences the bruin sprite's vertical motion once per video frame.

---
 rtl/flappy_pkg.sv | 29 ++
 rtl/flap_sync_edge.sv | 37 +++
 rtl/bruin_motion_ctrl.sv | 148 ++++++++++++++
 tb/tb_bruin_motion_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared game types and motion constants
// Purpose: game state encoding, screen geometry and the bruin motion tuning
//          constants shared by the motion controller and its helpers.
// Ports:   none (package)
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } game_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BRUIN_X  = 200;
  localparam int BRUIN_H  = 10;

  localparam logic        [8:0] Y_START   = 9'd240;
  localparam logic signed [10:0] Y_MIN_S  = 11'sd5;
  localparam logic signed [10:0] Y_MAX_S  = 11'sd470;
  localparam logic        [8:0] Y_MIN     = 9'd5;
  localparam logic        [8:0] Y_MAX     = 9'd470;
  localparam logic signed [4:0] FLAP_VEL  = -5'sd6;
  localparam logic signed [4:0] GRAVITY   = 5'sd1;
  localparam logic signed [4:0] VMAX      = 5'sd8;
  localparam logic        [2:0] FLAP_LOCK = 3'd4;
  localparam logic        [4:0] DEAD_HOLD = 5'd30;

endpackage

// File: rtl/flap_sync_edge.sv
// rtl/flap_sync_edge.sv - button synchronizer with rising-edge pulse
// Purpose: brings the asynchronous flap button into the clk domain through
//          two flops and emits a one-clk pulse on each synchronized rise.
// Ports:   clk, rst (async, active-high), async_in (raw button),
//          edge_pulse (one-clk pulse per rising edge).
module flap_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign edge_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/bruin_motion_ctrl.sv
// rtl/bruin_motion_ctrl.sv - per-frame bruin vertical motion and game FSM
// Purpose: owns IDLE/PLAY/DEAD, applies gravity and flap impulses once per
//          frame_tick, clamps to the playfield and reacts to collisions.
// Ports:   clk, rst (async, active-high), frame_tick (1-clk per frame),
//          flap_btn (raw async button), collide (level, PLAY only),
//          bruin_y[8:0] (sprite top), game_state[1:0], flap_ack (pulse when
//          a flap hits velocity), died (pulse on PLAY->DEAD).
module bruin_motion_ctrl
  import flappy_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       flap_btn,
  input  logic       collide,
  output logic [8:0] bruin_y,
  output logic [1:0] game_state,
  output logic       flap_ack,
  output logic       died
);

  logic flap_edge;

  flap_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (flap_btn),
    .edge_pulse (flap_edge)
  );

  game_state_t       state_q, state_d;
  logic [8:0]        y_q, y_d;
  logic signed [4:0] vel_q, vel_d;
  logic              pend_q, pend_d;
  logic [2:0]        lock_q, lock_d;
  logic [4:0]        dead_q, dead_d;
  logic              ack_q, ack_d;
  logic              died_q, died_d;

  logic              accept;
  logic              pend_eff;
  logic signed [4:0] vel_inc;
  logic signed [4:0] vel_n;
  logic signed [10:0] y_n;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    pend_d  = pend_q;
    lock_d  = lock_q;
    dead_d  = dead_q;
    ack_d   = 1'b0;
    died_d  = 1'b0;

    accept   = flap_edge && (lock_q == 3'd0);
    // An edge landing on the tick clk is folded into that tick's update.
    pend_eff = pend_q | accept;
    vel_inc  = vel_q + GRAVITY;
    vel_n    = pend_eff ? FLAP_VEL : ((vel_inc > VMAX) ? VMAX : vel_inc);
    y_n      = $signed({2'b00, y_q}) + {{6{vel_n[4]}}, vel_n};

    if (frame_tick && (lock_q != 3'd0)) begin
      lock_d = lock_q - 3'd1;
    end

    case (state_q)
      IDLE: begin
        y_d   = Y_START;
        vel_d = '0;
        if (accept) begin
          state_d = PLAY;
          pend_d  = 1'b1;
        end
      end
      PLAY: begin
        if (collide) begin
          // Collision beats a coincident tick: nothing of the tick survives.
          state_d = DEAD;
          died_d  = 1'b1;
          lock_d  = lock_q;
        end else if (frame_tick) begin
          if (pend_eff) begin
            ack_d  = 1'b1;
            pend_d = 1'b0;
            lock_d = FLAP_LOCK;
          end
          if (y_n <= Y_MIN_S) begin
            y_d   = Y_MIN;
            vel_d = '0;
          end else if (y_n >= Y_MAX_S) begin
            y_d     = Y_MAX;
            vel_d   = vel_n;
            state_d = DEAD;
            died_d  = 1'b1;
          end else begin
            y_d   = y_n[8:0];
            vel_d = vel_n;
          end
        end else if (accept) begin
          pend_d = 1'b1;
        end
      end
      DEAD: begin
        if (frame_tick && (dead_q != DEAD_HOLD)) begin
          dead_d = dead_q + 5'd1;
        end
        if (flap_edge && (dead_q == DEAD_HOLD)) begin
          state_d = IDLE;
          y_d     = Y_START;
          vel_d   = '0;
          pend_d  = 1'b0;
          dead_d  = '0;
          lock_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= Y_START;
      vel_q   <= '0;
      pend_q  <= 1'b0;
      lock_q  <= '0;
      dead_q  <= '0;
      ack_q   <= 1'b0;
      died_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      pend_q  <= pend_d;
      lock_q  <= lock_d;
      dead_q  <= dead_d;
      ack_q   <= ack_d;
      died_q  <= died_d;
    end
  end

  assign bruin_y    = y_q;
  assign game_state = state_q;
  assign flap_ack   = ack_q;
  assign died       = died_q;

endmodule

// File: tb/tb_bruin_motion_ctrl.sv
// tb/tb_bruin_motion_ctrl.sv - self-checking bench for bruin_motion_ctrl
module tb_bruin_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       flap_btn = 1'b0;
  logic       collide = 1'b0;
  logic [8:0] bruin_y;
  logic [1:0] game_state;
  logic       flap_ack;
  logic       died;

  bruin_motion_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .flap_btn   (flap_btn),
    .collide    (collide),
    .bruin_y    (bruin_y),
    .game_state (game_state),
    .flap_ack   (flap_ack),
    .died       (died)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference game model: plain integers, updated per frame / per press.
  int m_state, m_y, m_vel, m_pend, m_lock, m_dead;
  int e_ack, e_died;
  int exp_ack_total = 0, exp_died_total = 0;
  int ack_seen = 0, died_seen = 0;
  bit saw_ceiling;

  always @(posedge clk) begin
    if (flap_ack) ack_seen++;
    if (died) died_seen++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_y = 240; m_vel = 0; m_pend = 0; m_lock = 0; m_dead = 0;
  endtask

  task automatic model_frame(input bit tick, input bit col);
    e_ack = 0; e_died = 0;
    if (m_state == 1 && col) begin
      m_state = 2; e_died = 1;
    end else if (tick) begin
      if (m_lock > 0) m_lock--;
      if (m_state == 1) begin
        int ny;
        if (m_pend != 0) begin
          m_vel = -6; m_pend = 0; m_lock = 4; e_ack = 1;
        end else begin
          m_vel = (m_vel + 1 > 8) ? 8 : m_vel + 1;
        end
        ny = m_y + m_vel;
        if (ny <= 5) begin
          m_y = 5; m_vel = 0;
        end else if (ny >= 470) begin
          m_y = 470; m_state = 2; e_died = 1;
        end else begin
          m_y = ny;
        end
      end else if (m_state == 2) begin
        if (m_dead < 30) m_dead++;
      end
    end
    exp_ack_total  += e_ack;
    exp_died_total += e_died;
  endtask

  task automatic model_press();
    case (m_state)
      0: begin m_state = 1; m_pend = 1; end
      1: if (m_lock == 0) m_pend = 1;
      2: if (m_dead == 30) begin
           m_state = 0; m_y = 240; m_vel = 0; m_pend = 0; m_dead = 0; m_lock = 0;
         end
      default: ;
    endcase
  endtask

  task automatic check_state(input string tag);
    check({tag, "_state"}, int'(game_state), m_state);
    check({tag, "_y"}, int'(bruin_y), m_y);
  endtask

  // One clk with frame_tick and/or collide raised; pulses checked right after.
  task automatic step(input bit tick, input bit col, input string tag);
    @(negedge clk);
    frame_tick = tick;
    collide    = col;
    model_frame(tick, col);
    @(posedge clk);
    #1;
    check_state(tag);
    check({tag, "_ack"}, int'(flap_ack), e_ack);
    check({tag, "_died"}, int'(died), e_died);
    if (bruin_y == 9'd5) saw_ceiling = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    collide    = 1'b0;
  endtask

  task automatic press(input string tag);
    @(negedge clk);
    flap_btn = 1'b1;
    repeat (4) @(negedge clk);
    flap_btn = 1'b0;
    repeat (3) @(negedge clk);
    model_press();
    check_state(tag);
    check({tag, "_acks"}, ack_seen, exp_ack_total);
    check({tag, "_deaths"}, died_seen, exp_died_total);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    flap_btn = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_state({tag, "_async"});
    check({tag, "_ack"}, int'(flap_ack), 0);
    check({tag, "_died"}, int'(died), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    saw_ceiling = 1'b0;

    // Reset and idle frames.
    do_reset("rst0");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "idle_tick");

    // Flap from IDLE and the first three frames of the arc.
    press("idle_flap");
    step(1'b1, 1'b0, "arc_t1");
    check("arc_t1_y_abs", int'(bruin_y), 234);
    check("arc_t1_ack_abs", int'(flap_ack), 1);
    step(1'b1, 1'b0, "arc_t2");
    check("arc_t2_y_abs", int'(bruin_y), 229);
    step(1'b1, 1'b0, "arc_t3");
    check("arc_t3_y_abs", int'(bruin_y), 225);

    // Free fall to the ground line.
    for (int i = 0; i < 200 && m_state == 1; i++) step(1'b1, 1'b0, "fall");
    check("fall_dead_state", int'(game_state), 2);
    check("fall_ground_y", int'(bruin_y), 470);

    // Hold in DEAD: an early flap is ignored, the one after the hold re-arms.
    for (int i = 0; i < 29; i++) step(1'b1, 1'b0, "hold");
    press("early_rearm");
    check("early_rearm_abs", int'(game_state), 2);
    step(1'b1, 1'b0, "hold_last");
    press("rearm");
    check("rearm_y_abs", int'(bruin_y), 240);

    // Flap lockout.
    press("lock_start");
    step(1'b1, 1'b0, "lock_f0");
    step(1'b1, 1'b0, "lock_f1");
    step(1'b1, 1'b0, "lock_f2");
    press("lock_drop");
    step(1'b1, 1'b0, "lock_f3");
    step(1'b1, 1'b0, "lock_f4");
    press("lock_accept");
    step(1'b1, 1'b0, "lock_f5");
    check("lock_f5_ack_abs", int'(flap_ack), 1);

    // Climb into the ceiling with repeated flaps.
    for (int i = 0; i < 40 && !saw_ceiling; i++) begin
      press("climb_flap");
      for (int j = 0; j < 5; j++) step(1'b1, 1'b0, "climb");
    end
    check("ceiling_reached", int'(saw_ceiling), 1);
    check("ceiling_alive", int'(game_state), 1);

    // Collision coinciding with a tick, then reset while DEAD.
    step(1'b1, 1'b1, "crash");
    check("crash_state_abs", int'(game_state), 2);
    step(1'b1, 1'b0, "crash_after");
    do_reset("rst_dead");
    step(1'b1, 1'b0, "post_rst");

    // Randomized play against the model.
    for (int n = 0; n < 500; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 55)      step(1'b1, 1'b0, "rnd_tick");
      else if (r < 80) press("rnd_press");
      else if (r < 88) step(1'b1, 1'b1, "rnd_tick_col");
      else if (r < 97) step(1'b0, 1'b1, "rnd_col");
      else             do_reset("rnd_rst");
    end

    repeat (3) @(negedge clk);
    check("final_acks", ack_seen, exp_ack_total);
    check("final_deaths", died_seen, exp_died_total);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
